input_conditioner: RTL and testbench

Two-channel input conditioner that produces the clean A and B operands for the combinational OR stage. Each raw push-button or switch input goes through:
- a two-flop synchronizer;
- a counter-based debounce state machine.

The block drives glitch-free, CLK-synchronous levels, so the OR output, and any logic that registers it, never sees metastable or bouncing inputs. It sits between the board pins and the OR gate.

---
 rtl/input_conditioner.sv | 136 +++++++++++++
 tb/tb_input_conditioner.sv | 128 ++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: two-channel synchronizer + counter debounce producing clean A/B levels.
// Optional INPUT_COND_PULSE_EN adds registered 0->1 pulses on a_rise/b_rise.
`default_nettype none

module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b
`ifdef INPUT_COND_PULSE_EN
  ,
  output logic a_rise,
  output logic b_rise
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] lvl_nx;

  assign raw = {b_raw, a_raw};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          s1, s2;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        state <= LOW;
        cnt   <= '0;
        lvl_q <= 1'b0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        state <= state_nx;
        cnt   <= cnt_nx;
        lvl_q <= lvl_nx[i];
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
        LOW: begin
          if (s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nx = HIGH;
            end else begin
              state_nx = RISE_WAIT;
              cnt_nx   = CW'(1);
            end
          end
        end
        RISE_WAIT: begin
          if (!s2) begin
            state_nx = LOW;
            cnt_nx   = '0;
          end else if (cnt == LAST) begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        HIGH: begin
          if (!s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nx = LOW;
            end else begin
              state_nx = FALL_WAIT;
              cnt_nx   = CW'(1);
            end
          end
        end
        FALL_WAIT: begin
          if (s2) begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end else if (cnt == LAST) begin
            state_nx = LOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      endcase
    end

    // Level is registered alongside the state so it changes on the same edge.
    assign lvl_nx[i] = (state_nx == HIGH) || (state_nx == FALL_WAIT);
    assign lvl[i]    = lvl_q;
  end

  assign a = lvl[0];
  assign b = lvl[1];

`ifdef INPUT_COND_PULSE_EN
  logic [1:0] rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise_q <= 2'b00;
    else        rise_q <= lvl_nx & ~lvl;
  end

  assign a_rise = rise_q[0];
  assign b_rise = rise_q[1];
`else
  // Level-only build: no edge-detect registers.
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic a_raw, b_raw;
  logic a, b;
`ifdef INPUT_COND_PULSE_EN
  logic a_rise, b_rise;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b)
`ifdef INPUT_COND_PULSE_EN
    ,
    .a_rise(a_rise),
    .b_rise(b_rise)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then check levels and (if present) pulses.
  task automatic edge_chk(input string tag, input logic ea, input logic eb,
                          input logic ear, input logic ebr);
    @(posedge clk);
    #1;
    check({tag, "_a"}, {31'd0, a}, {31'd0, ea});
    check({tag, "_b"}, {31'd0, b}, {31'd0, eb});
`ifdef INPUT_COND_PULSE_EN
    check({tag, "_arise"}, {31'd0, a_rise}, {31'd0, ear});
    check({tag, "_brise"}, {31'd0, b_rise}, {31'd0, ebr});
`endif
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;

    // Reset held with both inputs high: levels stay 0.
    for (int i = 0; i < 10; i++) edge_chk("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) edge_chk("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    edge_chk("rst_rel_e6", 1'b1, 1'b1, 1'b1, 1'b1);
    edge_chk("rst_rel_e7", 1'b1, 1'b1, 1'b0, 1'b0);

    // Release of A while B stays high: A falls on edge 5, no pulse.
    a_raw = 1'b0;
    for (int i = 0; i <= 4; i++) edge_chk("rel", 1'b1, 1'b1, 1'b0, 1'b0);
    edge_chk("rel_e5", 1'b0, 1'b1, 1'b0, 1'b0);
    b_raw = 1'b0;
    settle(8);
    check("b_low", {31'd0, b}, 32'd0);

    // Clean press on A.
    a_raw = 1'b1;
    for (int i = 0; i <= 4; i++) edge_chk("press", 1'b0, 1'b0, 1'b0, 1'b0);
    edge_chk("press_e5", 1'b1, 1'b0, 1'b1, 1'b0);
    edge_chk("press_e6", 1'b1, 1'b0, 1'b0, 1'b0);
    a_raw = 1'b0;
    settle(8);
    check("a_low1", {31'd0, a}, 32'd0);

    // Bounce: 1 for edges 0-2, 0 at edge 3, then 1; rise lands on edge 9.
    a_raw = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i == 3) a_raw = 1'b0;
      if (i == 4) a_raw = 1'b1;
      edge_chk("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    edge_chk("bounce_e9", 1'b1, 1'b0, 1'b1, 1'b0);
    a_raw = 1'b0;
    settle(8);
    check("a_low2", {31'd0, a}, 32'd0);

    // Simultaneous press.
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 0; i <= 4; i++) edge_chk("simul", 1'b0, 1'b0, 1'b0, 1'b0);
    edge_chk("simul_e5", 1'b1, 1'b1, 1'b1, 1'b1);
    a_raw = 1'b0;
    settle(8);
    check("a_low3", {31'd0, a}, 32'd0);
    check("b_hold", {31'd0, b}, 32'd1);

    // Reset mid-debounce: A in RISE_WAIT (cnt=2) after edge 3, B high.
    a_raw = 1'b1;
    for (int i = 0; i <= 3; i++) edge_chk("mid", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", {31'd0, a}, 32'd0);
    check("mid_rst_b", {31'd0, b}, 32'd0);
    edge_chk("mid_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) edge_chk("mid_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    edge_chk("mid_rel_e6", 1'b1, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
